// File: rtl/tdm_demux_pkg.sv
// Shared types and constants for the TDM demultiplexer receive path.
package tdm_demux_pkg;

    localparam int unsigned NUM_CH   = 4;
    localparam int unsigned SLOT_W   = 2;
    localparam int unsigned ERR_W    = 4;
    localparam int unsigned MISS_W   = 4;

    // ui_in bit positions
    localparam int unsigned IDX_DATA = 0;
    localparam int unsigned IDX_SYNC = 1;
    localparam int unsigned IDX_EN   = 2;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/tdm_slot_tracker.sv
// Slot tracker: acquires frame sync, flywheels through missed syncs and
// counts misaligned syncs. Tells the datapath where to store each bit and
// when a complete frame is ready to publish.
module tdm_slot_tracker
    import tdm_demux_pkg::*;
#(
    parameter int unsigned MISS_MAX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slot_en,
    input  logic              frame_sync,
    output logic [SLOT_W-1:0] slot,
    output logic              locked,
    output logic [ERR_W-1:0]  err_cnt,
    output logic              wr_en_c,
    output logic [SLOT_W-1:0] wr_idx_c,
    output logic              publish_c
);

    state_e              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [MISS_W-1:0]   miss_q, miss_d;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [MISS_W-1:0]   miss_inc;

    assign miss_inc = MISS_W'(miss_q + MISS_W'(1));

    // State, slot, miss and error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= HUNT;
            slot_q  <= '0;
            miss_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
        end
    end

    // Next-state and write/publish decode; nothing moves without slot_en
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        miss_d    = miss_q;
        err_d     = err_q;
        wr_en_c   = 1'b0;
        wr_idx_c  = '0;
        publish_c = 1'b0;

        case (state_q)
            HUNT: begin
                if (slot_en && frame_sync) begin
                    wr_en_c = 1'b1;
                    slot_d  = SLOT_W'(1);
                    miss_d  = '0;
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (slot_en) begin
                    if (frame_sync) begin
                        // Any sync realigns; only an off-slot-0 one is an error
                        if (slot_q != '0 && err_q != '1) begin
                            err_d = ERR_W'(err_q + ERR_W'(1));
                        end
                        wr_en_c = 1'b1;
                        slot_d  = SLOT_W'(1);
                        miss_d  = '0;
                    end else if (slot_q == '0) begin
                        miss_d = miss_inc;
                        if (miss_inc == MISS_W'(MISS_MAX)) begin
                            state_d = HUNT;
                            slot_d  = '0;
                        end else begin
                            wr_en_c = 1'b1;
                            slot_d  = SLOT_W'(1);
                        end
                    end else if (slot_q != SLOT_W'(NUM_CH - 1)) begin
                        wr_en_c  = 1'b1;
                        wr_idx_c = slot_q;
                        slot_d   = SLOT_W'(slot_q + SLOT_W'(1));
                    end else begin
                        publish_c = 1'b1;
                        slot_d    = '0;
                    end
                end
            end
            default: begin
                state_d = HUNT;
                slot_d  = '0;
            end
        endcase
    end

    assign slot    = slot_q;
    assign locked  = (state_q == LOCKED);
    assign err_cnt = err_q;

endmodule

// File: rtl/tt_um_tdm_demux.sv
// 4:1 TDM receiver: rebuilds four 1-bit channels from one serial line and
// publishes them together once per complete frame.
module tt_um_tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned MISS_MAX = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic              tdm_data;
    logic              frame_sync;
    logic              slot_en;
    logic [SLOT_W-1:0] slot;
    logic              locked;
    logic [ERR_W-1:0]  err_cnt;
    logic              wr_en_c;
    logic [SLOT_W-1:0] wr_idx_c;
    logic              publish_c;

    logic [NUM_CH-2:0] shadow_q;
    logic [NUM_CH-1:0] ch_q;
    logic              frame_valid_q;
    logic              unused_ok;

    assign tdm_data   = ui_in[IDX_DATA];
    assign frame_sync = ui_in[IDX_SYNC];
    assign slot_en    = ui_in[IDX_EN];
    assign unused_ok  = &{1'b0, ena, ui_in[7:3], uio_in};

    tdm_slot_tracker #(
        .MISS_MAX (MISS_MAX)
    ) u_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .slot_en    (slot_en),
        .frame_sync (frame_sync),
        .slot       (slot),
        .locked     (locked),
        .err_cnt    (err_cnt),
        .wr_en_c    (wr_en_c),
        .wr_idx_c   (wr_idx_c),
        .publish_c  (publish_c)
    );

    // Shadow buffer for slots 0..2; slot 3 goes straight to the output register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                if (wr_en_c && wr_idx_c == SLOT_W'(i)) begin
                    shadow_q[i] <= tdm_data;
                end
            end
        end
    end

    // Publish the whole frame at once; frame_valid is a one-cycle pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ch_q          <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            frame_valid_q <= publish_c;
            if (publish_c) begin
                ch_q <= {tdm_data, shadow_q};
            end
        end
    end

    assign uo_out  = {slot, locked, frame_valid_q, ch_q};
    assign uio_out = {4'b0000, err_cnt};
    assign uio_oe  = 8'h0F;

endmodule
